// File: rtl/tick_gen.sv
// Programmable pulse-train source: prescaler divides clk_i by a latched divisor
// and emits one-cycle ticks, optionally in fixed-length bursts ending with done.
module tick_gen #(
   parameter int DIV_WIDTH   = 16,
   parameter int BURST_WIDTH = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic                   stop_i,
   input  logic                   pause_i,
   input  logic [DIV_WIDTH-1:0]   divisor_i,
   input  logic [BURST_WIDTH-1:0] burst_i,
   output logic                   tick_o,
   output logic                   done_o,
   output logic                   busy_o,
   output logic [BURST_WIDTH-1:0] tick_count_o
);

   // state | meaning
   // IDLE  | waiting for start; latches and tick_count retained
   // RUN   | prescaler counting, ticks issued at terminal count
   // PAUSE | prescaler and tick_count frozen
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [DIV_WIDTH-1:0]   prescale_q, prescale_d;
   logic [DIV_WIDTH-1:0]   div_q, div_d;
   logic [BURST_WIDTH-1:0] burst_q, burst_d;
   logic [BURST_WIDTH-1:0] count_q, count_d;
   logic                   tick_q, tick_d;
   logic                   done_q, done_d;
   logic [BURST_WIDTH-1:0] count_inc;

   assign count_inc = count_q + {{(BURST_WIDTH-1){1'b0}}, 1'b1};

   always_comb begin
      state_d    = state_q;
      prescale_d = prescale_q;
      div_d      = div_q;
      burst_d    = burst_q;
      count_d    = count_q;
      tick_d     = 1'b0;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i && !stop_i) begin
               div_d      = (divisor_i == '0) ? {{(DIV_WIDTH-1){1'b0}}, 1'b1} : divisor_i;
               burst_d    = burst_i;
               prescale_d = '0;
               count_d    = '0;
               state_d    = pause_i ? PAUSE : RUN;
            end
         end
         RUN, PAUSE: begin
            if (stop_i) begin
               state_d = IDLE;
            end else if (pause_i) begin
               state_d = PAUSE;
            end else begin
               // Leaving PAUSE counts on the same edge so paused cycles add exactly P to the period.
               state_d = RUN;
               if (prescale_q == div_q - {{(DIV_WIDTH-1){1'b0}}, 1'b1}) begin
                  prescale_d = '0;
                  tick_d     = 1'b1;
                  count_d    = count_inc;
                  if (burst_q != '0 && count_inc == burst_q) begin
                     done_d  = 1'b1;
                     state_d = IDLE;
                  end
               end else begin
                  prescale_d = prescale_q + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         prescale_q <= '0;
         div_q      <= '0;
         burst_q    <= '0;
         count_q    <= '0;
         tick_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         prescale_q <= prescale_d;
         div_q      <= div_d;
         burst_q    <= burst_d;
         count_q    <= count_d;
         tick_q     <= tick_d;
         done_q     <= done_d;
      end
   end

   assign tick_o       = tick_q;
   assign done_o       = done_q;
   assign busy_o       = (state_q != IDLE);
   assign tick_count_o = count_q;

endmodule

// File: tb/tb_tick_gen.sv
// Directed bench for tick_gen: table of burst runs plus pause, stop, consumer and reset sequences.
module tb_tick_gen;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i, stop_i, pause_i;
   logic [15:0] divisor_i;
   logic [7:0]  burst_i;
   logic        tick_o, done_o, busy_o;
   logic [7:0]  tick_count_o;

   int n_cmp = 0;
   int n_err = 0;

   tick_gen #(.DIV_WIDTH(16), .BURST_WIDTH(8)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .stop_i      (stop_i),
      .pause_i     (pause_i),
      .divisor_i   (divisor_i),
      .burst_i     (burst_i),
      .tick_o      (tick_o),
      .done_o      (done_o),
      .busy_o      (busy_o),
      .tick_count_o(tick_count_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int div;
      int burst;
      int d_eff;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Start one burst and follow it to completion; tick k must land on edge d_eff*k.
   task automatic run_vec(input int idx);
      int e, ticks, dones, done_e, bad;
      e = 0; ticks = 0; dones = 0; done_e = -1; bad = 0;
      divisor_i = 16'(vecs[idx].div);
      burst_i   = 8'(vecs[idx].burst);
      start_i   = 1'b1;
      step();
      start_i   = 1'b0;
      divisor_i = 16'hFFFF;
      burst_i   = 8'hFF;
      check($sformatf("v%0d busy_after_start", idx), busy_o, 1);
      while (busy_o && e < 400) begin
         step();
         e++;
         if (tick_o) begin
            ticks++;
            if (e != vecs[idx].d_eff * ticks) bad++;
         end
         if (done_o) begin
            dones++;
            done_e = e;
         end
      end
      check($sformatf("v%0d busy_end", idx), busy_o, 0);
      check($sformatf("v%0d tick_total", idx), ticks, vecs[idx].burst);
      check($sformatf("v%0d tick_spacing_errs", idx), bad, 0);
      check($sformatf("v%0d done_pulses", idx), dones, 1);
      check($sformatf("v%0d done_edge", idx), done_e, vecs[idx].d_eff * vecs[idx].burst);
      check($sformatf("v%0d tick_count", idx), tick_count_o, vecs[idx].burst);
      step();
      check($sformatf("v%0d tick_after", idx), tick_o, 0);
      check($sformatf("v%0d done_after", idx), done_o, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int e, ticks, prev, bad, cons, fires;
      int fire_e[3];

      vecs[0] = '{div: 4, burst: 3, d_eff: 4};
      vecs[1] = '{div: 0, burst: 5, d_eff: 1};
      vecs[2] = '{div: 1, burst: 5, d_eff: 1};
      vecs[3] = '{div: 2, burst: 4, d_eff: 2};
      vecs[4] = '{div: 7, burst: 1, d_eff: 7};
      vecs[5] = '{div: 3, burst: 6, d_eff: 3};

      rst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; pause_i = 1'b0;
      divisor_i = '0; burst_i = '0;
      #2;
      check("rst tick", tick_o, 0);
      check("rst done", done_o, 0);
      check("rst busy", busy_o, 0);
      check("rst count", tick_count_o, 0);
      #10 rst_i = 1'b0;
      step();

      for (int i = 0; i < 6; i++) run_vec(i);

      // Continuous run, D=10, pause sampled on edges 4..10, wrap after 256 ticks.
      divisor_i = 16'd10; burst_i = 8'd0; start_i = 1'b1;
      step();
      start_i = 1'b0;
      e = 0; ticks = 0; prev = 0; bad = 0;
      while (ticks < 256 && e < 3000) begin
         step();
         e++;
         if (e == 3)  pause_i = 1'b1;
         if (e == 10) begin
            check("pause busy held", busy_o, 1);
            pause_i = 1'b0;
         end
         if (tick_o) begin
            ticks++;
            if (ticks == 1) check("pause first_tick_edge", e, 17);
            else if (e - prev != 10) bad++;
            prev = e;
            if (ticks == 1)   check("cont count1", tick_count_o, 1);
            if (ticks == 255) check("cont count255", tick_count_o, 255);
            if (ticks == 256) check("cont count_wrap", tick_count_o, 0);
         end
      end
      check("cont ticks", ticks, 256);
      check("cont spacing_errs", bad, 0);
      check("cont done_never", done_o, 0);
      stop_i = 1'b1;
      step();
      stop_i = 1'b0;
      check("cont stop busy", busy_o, 0);

      // Stop coincident with second terminal count (edge 8).
      divisor_i = 16'd4; burst_i = 8'd2; start_i = 1'b1;
      step();
      start_i = 1'b0;
      for (int k = 1; k <= 4; k++) step();
      check("stop first tick", tick_o, 1);
      check("stop first count", tick_count_o, 1);
      for (int k = 5; k <= 7; k++) step();
      stop_i = 1'b1;
      step();
      stop_i = 1'b0;
      check("stop tick", tick_o, 0);
      check("stop done", done_o, 0);
      check("stop busy", busy_o, 0);
      check("stop count", tick_count_o, 1);
      step();
      check("stop stays idle", busy_o, 0);

      // D=3 continuous into a count-to-10 consumer; mid-run start with new divisor must be ignored.
      divisor_i = 16'd3; burst_i = 8'd0; start_i = 1'b1;
      step();
      start_i = 1'b0;
      e = 0; ticks = 0; cons = 0; fires = 0;
      while (ticks < 30 && e < 200) begin
         step();
         e++;
         if (e == 5) begin start_i = 1'b1; divisor_i = 16'd7; end
         if (e == 6) start_i = 1'b0;
         if (tick_o) begin
            ticks++;
            cons++;
            if (cons == 10) begin
               cons = 0;
               if (fires < 3) fire_e[fires] = e;
               fires++;
            end
         end
      end
      check("cons fires", fires, 3);
      check("cons first_fire_edge", fire_e[0], 30);
      check("cons gap1", fire_e[1] - fire_e[0], 30);
      check("cons gap2", fire_e[2] - fire_e[1], 30);
      stop_i = 1'b1;
      step();
      stop_i = 1'b0;

      // Asynchronous reset between edges while a tick is high.
      divisor_i = 16'd4; burst_i = 8'd3; start_i = 1'b1;
      step();
      start_i = 1'b0;
      for (int k = 1; k <= 4; k++) step();
      check("arst pre tick", tick_o, 1);
      #2 rst_i = 1'b1;
      #1;
      check("arst tick", tick_o, 0);
      check("arst busy", busy_o, 0);
      check("arst count", tick_count_o, 0);
      check("arst done", done_o, 0);
      #3 rst_i = 1'b0;
      step();
      run_vec(0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
